lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Memory-access stage directly downstream of the EX-stage ALU in the RV32I pipeline.
- Consumes the registered ALU result as the effective address, plus Rs2 as store data.
- Runs RV32I loads and stores on a req/gnt/rvalid data-memory bus.
- Aligns and extends load data for writeback.
- Stalls upstream while a transaction is outstanding.

Parameters:
XLEN, 32, datapath and address width.
BE_W, XLEN/8, byte-enable width (4 at default).

Ports:
CLK  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ex_valid  in  1  EX presents a memory op this cycle.
ex_addr  in  XLEN  effective address (ALU Result).
ex_wdata  in  XLEN  store data (Rs2 value).
ex_funct3  in  3  RV32I load/store funct3.
ex_mem_rd  in  1  op is a load.
ex_mem_wr  in  1  op is a store.
lsu_busy  out  1  stall to upstream; high whenever FSM is not IDLE.
dmem_req  out  1  bus request.
dmem_we  out  1  1 = write.
dmem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}.
dmem_wdata  out  XLEN  lane-replicated store data.
dmem_be  out  BE_W  byte enables (0 for loads).
dmem_gnt  in  1  bus accepted request this cycle.
dmem_rvalid  in  1  read data valid.
dmem_rdata  in  XLEN  read word.
wb_valid  out  1  one-cycle pulse: load result valid.
wb_data  out  XLEN  aligned, extended load result.
lsu_err  out  1  one-cycle pulse: misaligned or illegal op.

Behaviour:
- Reset (rst=1, async): state=IDLE. All outputs 0; internal address/data/funct3 registers 0. Reset mid-transaction abandons the op.
- Accept condition: ex_valid=1 & lsu_busy=0 & (ex_mem_rd|ex_mem_wr). Upstream holds ex_* stable while lsu_busy=1. Payload (addr, wdata, funct3, rd/wr) is captured on acceptance.
- Illegal ops raise lsu_err=1 the cycle after acceptance, with no bus activity, no wb_valid and state staying IDLE. Illegal means any of:
  - ex_mem_rd & ex_mem_wr both set;
  - load funct3 in {3,6,7};
  - store funct3 >2;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- FSM IDLE -> REQ on legal accept.
- REQ: dmem_req=1. addr/we/be/wdata are held stable until dmem_gnt=1. Then a store goes to IDLE and a load goes to WAIT.
- WAIT: dmem_req=0. dmem_rvalid is sampled only here, so the earliest rvalid is the cycle after gnt. On rvalid, the FSM captures the load result and goes to RESP.
- RESP: wb_valid=1 for exactly one cycle; wb_data holds until the next load completes. Then IDLE.
- lsu_busy = (state != IDLE), registered via state. On the accept cycle itself lsu_busy=0.
- dmem_req, dmem_we, dmem_be and dmem_wdata are driven from registers. No combinational path from ex_* to dmem_*.
- Store lane rules:
  - SB: wdata = byte replicated x4; be = 4'b0001 << addr[1:0].
  - SH: wdata = half replicated x2; be = 4'b0011 << {addr[1],1'b0}.
  - SW: be = 4'b1111.
- Load extract: byte lane = addr[1:0], half lane = addr[1].
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: pass-through.
- rvalid or gnt arriving in IDLE/RESP (stray or post-reset) is ignored.
- Timing with gnt in the same cycle as req:
  - Load: accept c0, req c1, rvalid c2, wb_valid c3, busy low c4.
  - Store: accept c0, req+gnt c1, busy low c2.
- Bus stalls: gnt delayed N cycles extends REQ by N; rvalid delay extends WAIT. There are no timeouts.

Test Plan:
- LB addr=0x1003, rdata=0x80AB_CDEF, immediate gnt and rvalid -> dmem_addr=0x1000, be=0, wb_data=0xFFFFFF80, wb_valid pulse at c3; LBU same -> 0x00000080.
- SH addr=0x2002, Rs2=0x1234_BEEF, gnt held low 3 cycles -> req and payload stable 4 cycles, be=4'b1100, wdata=0xBEEFBEEF, lsu_busy 1 through gnt cycle then 0.
- LW addr=0x3001 -> lsu_err pulse c1, dmem_req never asserted, wb_valid stays 0, lsu_busy stays 0.
- Load accepted, gnt given, rst asserted in WAIT, then rvalid arrives -> all outputs 0 immediately, FSM IDLE, no wb_valid.
- Back-to-back SW 0x10 then LHU 0x12 (rdata=0xF00D_0000), second op held under busy -> second req starts the cycle after busy drops, wb_data=0x0000F00D.
- ex_mem_rd=ex_mem_wr=1 -> lsu_err pulse, no bus traffic.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// RV32I memory-access stage: loads/stores on a req/gnt/rvalid bus.
// Aligns store lanes, extracts and extends load data for writeback.
module lsu_mem_stage #(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_rd,
    input  logic            ex_mem_wr,
    output logic            lsu_busy,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic            lsu_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q;
    logic [1:0]      alo_q;
    logic [2:0]      f3_q;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [BE_W-1:0] be_q;
    logic            wbv_q;
    logic [XLEN-1:0] wbd_q;
    logic            err_q;

    logic            accept;
    logic            illegal;
    logic [BE_W-1:0] be_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] ld_d;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;

    assign accept = ex_valid && (state_q == S_IDLE) && (ex_mem_rd || ex_mem_wr);

    // Classify the presented op as illegal (conflict, bad funct3, misaligned).
    always_comb begin
        illegal = 1'b0;
        if (ex_mem_rd && ex_mem_wr) begin
            illegal = 1'b1;
        end else if (ex_mem_rd && (ex_funct3 == 3'd3 || ex_funct3[2:1] == 2'b11)) begin
            illegal = 1'b1;
        end else if (ex_mem_wr && ex_funct3 > 3'd2) begin
            illegal = 1'b1;
        end else if (ex_funct3[1:0] == 2'b01 && ex_addr[0]) begin
            illegal = 1'b1;
        end else if (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
    end

    // Store lane placement: replicate data, steer byte enables by address.
    always_comb begin
        be_d    = '1;
        wdata_d = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                be_d    = BE_W'(1) << ex_addr[1:0];
                wdata_d = {BE_W{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = BE_W'(3) << {ex_addr[1], 1'b0};
                wdata_d = {(BE_W / 2){ex_wdata[15:0]}};
            end
            default: begin
                be_d    = '1;
                wdata_d = ex_wdata;
            end
        endcase
    end

    // Load extraction from the captured lane and funct3.
    always_comb begin
        ld_b = dmem_rdata[{alo_q, 3'b000} +: 8];
        ld_h = dmem_rdata[{alo_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    ld_d = {{(XLEN - 8){ld_b[7]}}, ld_b};
            3'd4:    ld_d = {{(XLEN - 8){1'b0}}, ld_b};
            3'd1:    ld_d = {{(XLEN - 16){ld_h[15]}}, ld_h};
            3'd5:    ld_d = {{(XLEN - 16){1'b0}}, ld_h};
            default: ld_d = dmem_rdata;
        endcase
    end

    // Transaction FSM with registered bus, writeback and error outputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            alo_q   <= '0;
            f3_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wbv_q   <= 1'b0;
            wbd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            wbv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        alo_q <= ex_addr[1:0];
                        f3_q  <= ex_funct3;
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            we_q    <= ex_mem_wr;
                            addr_q  <= {ex_addr[XLEN-1:2], 2'b00};
                            be_q    <= ex_mem_wr ? be_d : '0;
                            wdata_q <= ex_mem_wr ? wdata_d : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= '0;
                        state_q <= we_q ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        wbd_q   <= ld_d;
                        wbv_q   <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu_busy   = (state_q != S_IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wbv_q;
    assign wb_data    = wbd_q;
    assign lsu_err    = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage.
// Random and directed ops against a behavioural load/store model.
module tb_lsu_mem_stage;

    logic        CLK = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [2:0]  ex_funct3;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        lsu_busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        lsu_err;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    lsu_mem_stage dut (
        .CLK(CLK), .rst(rst),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_funct3(ex_funct3), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .lsu_busy(lsu_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .lsu_err(lsu_err)
    );

    // ---- behavioural model ----
    function automatic bit m_illegal(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        int sz;
        sz = 1 << (f3 % 4);
        if (rd && wr) return 1;
        if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
        if (wr && f3 > 2) return 1;
        if (sz == 2 && (a % 2) != 0) return 1;
        if (sz == 4 && (a % 4) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
        int n;
        int m;
        n = 1 << (f3 % 4);
        m = ((1 << n) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
        case (f3 % 4)
            0: return {24'b0, d[7:0]} * 32'h0101_0101;
            1: return {16'b0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] r);
        logic [31:0] v;
        int sh;
        sh = 8 * (a % 4);
        case (f3)
            0, 4: begin
                v = (r >> sh) & 32'hFF;
                if (f3 == 0 && v >= 128) v = v - 32'd256;
            end
            1, 5: begin
                v = (r >> sh) & 32'hFFFF;
                if (f3 == 1 && v >= 32768) v = v - 32'd65536;
            end
            default: v = r;
        endcase
        return v;
    endfunction

    // ---- one complete op with bus responder and inline checks ----
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int gd, input int rvd);
        bit          ill;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eld;
        ill = m_illegal(rd, wr, f3, a);
        ebe = wr ? m_be(f3, a) : 4'b0;
        ewd = m_wdata(f3, wd);
        eld = m_load(f3, a, rdat);
        @(negedge CLK);
        checks++;
        if (lsu_busy !== 1'b0)
            begin errors++; $display("FAIL idle_before_op busy=%b exp=0", lsu_busy); end
        ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = wr;
        ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (ill) begin
            @(negedge CLK);
            ex_valid = 1'b0;
            checks++;
            if (lsu_err !== 1'b1 || dmem_req !== 1'b0 || lsu_busy !== 1'b0)
                begin errors++; $display("FAIL illegal_c1 err=%b req=%b busy=%b exp=1,0,0", lsu_err, dmem_req, lsu_busy); end
            @(negedge CLK);
            checks++;
            if (lsu_err !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b0 || lsu_busy !== 1'b0)
                begin errors++; $display("FAIL illegal_c2 err=%b req=%b wbv=%b busy=%b exp=0", lsu_err, dmem_req, wb_valid, lsu_busy); end
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            @(negedge CLK);
            ex_valid = 1'b0;
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== wr || dmem_addr !== {a[31:2], 2'b00} ||
                dmem_be !== ebe || (wr && dmem_wdata !== ewd) || lsu_busy !== 1'b1 || lsu_err !== 1'b0)
                begin errors++;
                $display("FAIL req_cycle%0d req=%b we=%b addr=%h be=%b wd=%h busy=%b exp 1,%b,%h,%b,%h,1",
                         k, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, lsu_busy,
                         wr, {a[31:2], 2'b00}, ebe, ewd); end
            dmem_gnt = (k == gd);
        end
        @(negedge CLK);
        dmem_gnt = 1'b0;
        if (wr) begin
            checks++;
            if (lsu_busy !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b0)
                begin errors++; $display("FAIL store_done busy=%b req=%b wbv=%b exp=0", lsu_busy, dmem_req, wb_valid); end
            return;
        end
        for (int j = 0; j <= rvd; j++) begin
            if (j > 0) @(negedge CLK);
            checks++;
            if (dmem_req !== 1'b0 || lsu_busy !== 1'b1 || wb_valid !== 1'b0)
                begin errors++; $display("FAIL wait_cycle%0d req=%b busy=%b wbv=%b exp 0,1,0", j, dmem_req, lsu_busy, wb_valid); end
            dmem_rvalid = (j == rvd);
            dmem_rdata = (j == rvd) ? rdat : $urandom;
        end
        @(negedge CLK);
        dmem_rvalid = 1'b0;
        dmem_rdata = $urandom;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== eld || lsu_busy !== 1'b1)
            begin errors++; $display("FAIL load_resp wbv=%b data=%h busy=%b exp 1,%h,1", wb_valid, wb_data, lsu_busy, eld); end
        @(negedge CLK);
        checks++;
        if (wb_valid !== 1'b0 || lsu_busy !== 1'b0 || wb_data !== eld)
            begin errors++; $display("FAIL load_after wbv=%b busy=%b data=%h exp 0,0,%h", wb_valid, lsu_busy, wb_data, eld); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_valid = 0; ex_addr = '0; ex_wdata = '0; ex_funct3 = '0;
        ex_mem_rd = 0; ex_mem_wr = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({lsu_busy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data, lsu_err} !== '0)
            begin errors++; $display("FAIL reset_outputs busy=%b req=%b addr=%h wd=%h be=%b wbv=%b wbd=%h err=%b exp all 0",
                                     lsu_busy, dmem_req, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data, lsu_err); end
        rst = 1'b0;
    endtask

    task automatic test_lb_lbu();
        run_op(1, 0, 3'd0, 32'h1003, 32'h0, 32'h80AB_CDEF, 0, 0);
        checks++;
        if (wb_data !== 32'hFFFF_FF80)
            begin errors++; $display("FAIL lb_value got=%h exp=ffffff80", wb_data); end
        run_op(1, 0, 3'd4, 32'h1003, 32'h0, 32'h80AB_CDEF, 0, 0);
        checks++;
        if (wb_data !== 32'h0000_0080)
            begin errors++; $display("FAIL lbu_value got=%h exp=00000080", wb_data); end
    endtask

    task automatic test_sh_stall();
        run_op(0, 1, 3'd1, 32'h2002, 32'h1234_BEEF, 32'h0, 3, 0);
    endtask

    task automatic test_illegal();
        run_op(1, 0, 3'd2, 32'h3001, 32'h0, 32'h0, 0, 0);
        run_op(1, 1, 3'd2, 32'h4000, 32'h55, 32'h0, 0, 0);
        run_op(0, 1, 3'd4, 32'h4000, 32'h55, 32'h0, 0, 0);
        run_op(1, 0, 3'd5, 32'h4001, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_stray();
        @(negedge CLK);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (lsu_busy !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b0)
                begin errors++; $display("FAIL stray busy=%b req=%b wbv=%b exp=0", lsu_busy, dmem_req, wb_valid); end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        ex_valid = 1; ex_mem_rd = 1; ex_mem_wr = 0; ex_funct3 = 3'd2; ex_addr = 32'h500;
        @(negedge CLK);
        ex_valid = 0; dmem_gnt = 1;
        @(negedge CLK);
        dmem_gnt = 0;
        checks++;
        if (lsu_busy !== 1'b1 || dmem_req !== 1'b0)
            begin errors++; $display("FAIL mid_wait busy=%b req=%b exp 1,0", lsu_busy, dmem_req); end
        rst = 1'b1;
        #1;
        checks++;
        if ({lsu_busy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data, lsu_err} !== '0)
            begin errors++; $display("FAIL mid_reset busy=%b req=%b addr=%h wbv=%b wbd=%h exp all 0", lsu_busy, dmem_req, dmem_addr, wb_valid, wb_data); end
        @(negedge CLK);
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        repeat (2) begin
            @(negedge CLK);
            dmem_rvalid = 1'b0;
            checks++;
            if (wb_valid !== 1'b0 || lsu_busy !== 1'b0 || wb_data !== 32'h0)
                begin errors++; $display("FAIL post_reset_rvalid wbv=%b busy=%b wbd=%h exp 0,0,0", wb_valid, lsu_busy, wb_data); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        ex_valid = 1; ex_mem_rd = 0; ex_mem_wr = 1; ex_funct3 = 3'd2;
        ex_addr = 32'h10; ex_wdata = 32'hCAFE_F00D;
        @(negedge CLK);
        checks++;
        if (dmem_req !== 1'b1 || dmem_be !== 4'hF || dmem_wdata !== 32'hCAFE_F00D || dmem_addr !== 32'h10)
            begin errors++; $display("FAIL b2b_sw req=%b be=%b wd=%h addr=%h", dmem_req, dmem_be, dmem_wdata, dmem_addr); end
        dmem_gnt = 1;
        ex_mem_rd = 1; ex_mem_wr = 0; ex_funct3 = 3'd5; ex_addr = 32'h12;
        @(negedge CLK);
        dmem_gnt = 0;
        checks++;
        if (lsu_busy !== 1'b0 || dmem_req !== 1'b0)
            begin errors++; $display("FAIL b2b_gap busy=%b req=%b exp 0,0", lsu_busy, dmem_req); end
        @(negedge CLK);
        ex_valid = 0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h10 || dmem_be !== 4'h0)
            begin errors++; $display("FAIL b2b_lhu_req req=%b we=%b addr=%h be=%b exp 1,0,10,0", dmem_req, dmem_we, dmem_addr, dmem_be); end
        dmem_gnt = 1;
        @(negedge CLK);
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hF00D_0000;
        @(negedge CLK);
        dmem_rvalid = 0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_F00D)
            begin errors++; $display("FAIL b2b_lhu_data wbv=%b data=%h exp 1,0000f00d", wb_valid, wb_data); end
        @(negedge CLK);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            bit rd;
            bit wr;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            rd = (kind < 5) || (kind == 9);
            wr = (kind >= 5);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_op(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lb_lbu();
        test_sh_stall();
        test_illegal();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
